// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch unit: sequential fetch into a small {pc, instr} FIFO with redirect and misalign halt
module if_prefetch #(
  parameter int              XLEN        = 32,
  parameter int              IMEM_ADDR_W = 10,
  parameter int              FIFO_DEPTH  = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCSrc,
  input  logic [XLEN-1:0]        PC_Branch,
  input  logic                   ready_ID,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]        imem_rdata,
  output logic                   valid_IF,
  output logic [XLEN-1:0]        PC_IF,
  output logic [XLEN-1:0]        INSTRUCTION_IF,
  output logic                   misalign_IF
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc;
  logic              inflight;
  logic [XLEN-1:0]   inflight_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [XLEN-1:0]   pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0]   instr_mem [FIFO_DEPTH];
  logic [CNT_W:0]    occupancy;
  logic              push, pop;

  // Slots already promised (buffered plus the one response on its way) bound issue.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = (state_q == RUN) && !PCSrc && (occupancy < DEPTH_V);
  assign imem_addr = fetch_pc[IMEM_ADDR_W+1:2];

  assign valid_IF       = (count != '0);
  assign push           = inflight && !PCSrc;
  assign pop            = valid_IF && ready_ID && !PCSrc;
  assign PC_IF          = valid_IF ? pc_mem[rd_ptr]    : '0;
  assign INSTRUCTION_IF = valid_IF ? instr_mem[rd_ptr] : '0;
  assign misalign_IF    = (state_q == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (PCSrc) state_d = (PC_Branch[1:0] == 2'b00) ? RUN : HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (PCSrc) begin
      fetch_pc <= PC_Branch;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (imem_req) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end else if (inflight) begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed and randomized checks of if_prefetch against an in-order PC stream model
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset, PCSrc, ready_ID;
  logic [31:0] PC_Branch, imem_rdata, PC_IF, INSTRUCTION_IF;
  logic        imem_req, valid_IF, misalign_IF;
  logic [9:0]  imem_addr;

  logic        w_reset, w_PCSrc, w_ready;
  logic [31:0] w_branch, w_rdata, w_pc, w_instr;
  logic        w_req, w_valid, w_mis;
  logic [9:0]  w_addr;

  logic [31:0] mem [1024];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic        halted;

  always #5 clk = ~clk;

  if_prefetch #(.XLEN(32), .IMEM_ADDR_W(10), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Branch(PC_Branch), .ready_ID(ready_ID),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .valid_IF(valid_IF), .PC_IF(PC_IF), .INSTRUCTION_IF(INSTRUCTION_IF), .misalign_IF(misalign_IF)
  );

  if_prefetch #(.XLEN(32), .IMEM_ADDR_W(10), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(w_reset), .PCSrc(w_PCSrc), .PC_Branch(w_branch), .ready_ID(w_ready),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .valid_IF(w_valid), .PC_IF(w_pc), .INSTRUCTION_IF(w_instr), .misalign_IF(w_mis)
  );

  // Synchronous memories: data for a request appears one cycle later.
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];
  always @(posedge clk) if (w_req) w_rdata <= 32'hA000_0000 + {22'h0, w_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; PCSrc = 1'b0; PC_Branch = '0; ready_ID = 1'b0;
    w_reset = 1'b0; w_PCSrc = 1'b0; w_branch = '0; w_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    @(negedge clk);
    check("rst_valid", {31'h0, valid_IF}, 32'h0);
    check("rst_pc", PC_IF, 32'h0);
    check("rst_instr", INSTRUCTION_IF, 32'h0);
    check("rst_mis", {31'h0, misalign_IF}, 32'h0);
    check("rst_addr", {22'h0, imem_addr}, 32'h0);

    // Streaming with consumer always ready.
    ready_ID = 1'b1; reset = 1'b1;
    check("s_req0", {31'h0, imem_req}, 32'h1);
    tick();
    check("s_valid_e1", {31'h0, valid_IF}, 32'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("s_valid", {31'h0, valid_IF}, 32'h1);
      check("s_pc", PC_IF, 32'(4 * k));
      check("s_instr", INSTRUCTION_IF, 32'h1000_0000 + 32'(k));
      tick();
    end

    // Backpressure: fill to depth, then drain with no bubble.
    reset = 1'b0; ready_ID = 1'b0; tick(); reset = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("bp_req", {31'h0, imem_req}, 32'h0);
    ready_ID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'h0, valid_IF}, 32'h1);
      check("bp_pc", PC_IF, 32'(4 * k));
      tick();
    end

    // Redirect with three buffered and one in flight.
    reset = 1'b0; ready_ID = 1'b0; tick(); reset = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("rd_pre_pc", PC_IF, 32'h0);
    PCSrc = 1'b1; PC_Branch = 32'h40;
    check("rd_req_block", {31'h0, imem_req}, 32'h0);
    tick(); PCSrc = 1'b0; ready_ID = 1'b1;
    check("rd_flush", {31'h0, valid_IF}, 32'h0);
    tick();
    check("rd_issue", {31'h0, valid_IF}, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("rd_pc", PC_IF, 32'h40 + 32'(4 * k));
      check("rd_instr", INSTRUCTION_IF, 32'h1000_0010 + 32'(k));
      tick();
    end

    // Misaligned target halts until an aligned redirect.
    PCSrc = 1'b1; PC_Branch = 32'h42; tick(); PCSrc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("h_mis", {31'h0, misalign_IF}, 32'h1);
      check("h_req", {31'h0, imem_req}, 32'h0);
      check("h_valid", {31'h0, valid_IF}, 32'h0);
      tick();
    end
    PCSrc = 1'b1; PC_Branch = 32'h80; tick(); PCSrc = 1'b0;
    check("h_exit_mis", {31'h0, misalign_IF}, 32'h0);
    tick(); tick();
    check("h_exit_pc", PC_IF, 32'h80);
    check("h_exit_valid", {31'h0, valid_IF}, 32'h1);

    // Asynchronous reset mid-stream with two entries buffered.
    reset = 1'b0; ready_ID = 1'b0; tick(); reset = 1'b1;
    tick(); tick(); tick();
    check("ar_pre_pc", PC_IF, 32'h0);
    reset = 1'b0; #1;
    check("ar_valid", {31'h0, valid_IF}, 32'h0);
    check("ar_pc", PC_IF, 32'h0);
    check("ar_instr", INSTRUCTION_IF, 32'h0);
    @(negedge clk); reset = 1'b1; ready_ID = 1'b1;
    tick(); tick();
    check("ar_restart", PC_IF, 32'h0);

    // PC wrap at the top of the address space.
    w_reset = 1'b1;
    check("w_addr0", {22'h0, w_addr}, 32'h3FE);
    tick();
    check("w_addr1", {22'h0, w_addr}, 32'h3FF);
    tick();
    check("w_addr2", {22'h0, w_addr}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("w_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      check("w_instr", w_instr, 32'hA000_0000 + {22'h0, 10'(10'h3FE + 10'(k))});
      tick();
    end

    // Randomized traffic against the in-order stream model.
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    tick(); reset = 1'b1;
    exp_pc = 32'h0; halted = 1'b0;
    for (int i = 0; i < 600; i++) begin
      check("r_mis", {31'h0, misalign_IF}, {31'h0, halted});
      if (halted) begin
        check("r_h_valid", {31'h0, valid_IF}, 32'h0);
        check("r_h_req", {31'h0, imem_req}, 32'h0);
      end else if (valid_IF) begin
        check("r_pc", PC_IF, exp_pc);
        check("r_instr", INSTRUCTION_IF, mem[exp_pc[11:2]]);
      end else begin
        check("r_idle_pc", PC_IF, 32'h0);
      end
      ready_ID = ($urandom_range(0, 2) != 0);
      PCSrc = ($urandom_range(0, 15) == 0);
      if (PCSrc) begin
        PC_Branch = {20'h0, 10'($urandom_range(0, 1023)),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        exp_pc = PC_Branch;
        halted = (PC_Branch[1:0] != 2'b00);
      end else if (valid_IF && ready_ID) begin
        exp_pc = exp_pc + 32'h4;
      end
      tick();
    end
    PCSrc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC and instruction width.
REQ-002 Parameter IMEM_ADDR_W, default 10, SHALL set the instruction-memory word-address width.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, at least 2), SHALL set the prefetch buffer entries.
REQ-004 Parameter RESET_PC, default 0, SHALL set the first fetch address.
REQ-005 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- PCSrc  in  1  redirect request.
- PC_Branch  in  XLEN  redirect target.
- ready_ID  in  1  consumer accepts the head entry.
- imem_req  out  1  memory read strobe.
- imem_addr  out  IMEM_ADDR_W  word address.
- imem_rdata  in  XLEN  read data, valid one cycle after the request.
- valid_IF  out  1  head entry valid.
- PC_IF  out  XLEN  head entry PC.
- INSTRUCTION_IF  out  XLEN  head entry instruction.
- misalign_IF  out  1  halted on a misaligned target.

Function
REQ-006 Internal state SHALL be: fetch_pc; inflight flag plus inflight_pc; FIFO of {pc, instr} with count 0..FIFO_DEPTH; FSM state RUN or HALT.
REQ-007 imem_addr SHALL equal fetch_pc[IMEM_ADDR_W+1:2], combinational.
REQ-008 imem_req SHALL be high only when all of the following hold:
- state is RUN;
- PCSrc is low;
- count + inflight < FIFO_DEPTH.
REQ-009 On a clock edge with imem_req high:
- inflight SHALL be set to 1;
- inflight_pc SHALL take fetch_pc;
- fetch_pc SHALL take fetch_pc+4, modulo 2^XLEN (wraps silently).
REQ-010 On a clock edge with inflight high and PCSrc low, {inflight_pc, imem_rdata} SHALL be pushed into the FIFO tail; inflight clears unless a new request issues in the same cycle.
REQ-011 valid_IF SHALL equal (count != 0); PC_IF and INSTRUCTION_IF SHALL present the head entry; when count is 0 both SHALL be 0.
REQ-012 A head entry SHALL be popped on an edge where valid_IF and ready_ID are both high.
REQ-013 A simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-014 Sequential fetch SHALL sustain one instruction per cycle when ready_ID is held high.
REQ-015 On an edge with PCSrc high, the block SHALL:
- flush the FIFO (count 0);
- discard any in-flight response (inflight 0, no push);
- load fetch_pc with PC_Branch;
- ignore a pop in the same cycle.
REQ-016 If PC_Branch[1:0] is 0 at redirect, the state SHALL be RUN, with the first target request in the following cycle.
REQ-017 If PC_Branch[1:0] is not 0 at redirect, the state SHALL become HALT.
REQ-018 In HALT:
- misalign_IF SHALL be 1;
- no requests SHALL issue;
- valid_IF SHALL be 0.
REQ-019 HALT SHALL be left only by a later redirect with an aligned target, which sets misalign_IF to 0 on that edge.
REQ-020 Redirect-to-first-valid latency SHALL be 3 edges: the redirect edge, the issue edge and the push edge.
REQ-021 ready_ID asserted while valid_IF is low SHALL have no effect.

Reset
REQ-022 While reset is low, the block SHALL asynchronously hold:
- fetch_pc = RESET_PC;
- inflight = 0 and count = 0;
- state RUN;
- valid_IF = 0, PC_IF = 0, INSTRUCTION_IF = 0, misalign_IF = 0.
REQ-023 Asserting reset mid-operation SHALL discard all buffered and in-flight instructions immediately.
REQ-024 After reset releases, the first request SHALL issue on the first edge, with valid_IF high after the second edge showing PC_IF = RESET_PC.

Verification
REQ-025 Reset then ready_ID = 1, memory word n = 0x1000_0000+n -> valid_IF from the 2nd edge; PC_IF 0,4,8,... with matching words; one per cycle.
REQ-026 ready_ID = 0 from reset for 10 cycles -> count saturates at 4 (PCs 0..12), imem_req low thereafter; raising ready_ID drains 0,4,8,12,16 in order with no gap.
REQ-027 Redirect PCSrc = 1, PC_Branch = 0x40 while 3 entries are buffered and 1 is in flight -> valid_IF low next cycle; next valid PC_IF = 0x40 after 3 edges; no stale PCs appear.
REQ-028 Redirect to 0x42 -> misalign_IF = 1, imem_req = 0, valid_IF = 0 indefinitely; then a redirect to 0x80 -> misalign_IF = 0 and PC_IF = 0x80 appears.
REQ-029 Reset pulsed low mid-stream with 2 entries buffered -> outputs 0 immediately; after release PC_IF restarts at RESET_PC.
REQ-030 RESET_PC = 0xFFFF_FFF8 with XLEN = 32 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap), and imem_addr wraps accordingly.
